// File: rtl/alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arb : two requesters share one combinational ALU, one result slot
//                 each. Build option ALU_ARB_FIXED_PRIO_EN = requester 0 wins.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module alu_share_arb (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [31:0] in0_scr0,
  input  logic [31:0] in0_scr1,
  input  logic [11:0] in0_aluop,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [31:0] in1_scr0,
  input  logic [31:0] in1_scr1,
  input  logic [11:0] in1_aluop,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [31:0] out0_result,
  output logic        out0_overflow,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic [31:0] out1_result,
  output logic        out1_overflow,
  output logic [31:0] alu_scr0,
  output logic [31:0] alu_scr1,
  output logic [11:0] alu_aluop,
  input  logic [31:0] alu_aluso,
  input  logic        alu_overflow
);

  logic w_elig0, w_elig1, w_grant0, w_grant1;

  // A requester may issue only when its slot is empty or being drained now.
  assign w_elig0 = in0_valid & (~out0_valid | out0_ready);
  assign w_elig1 = in1_valid & (~out1_valid | out1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant0 = resetn & w_elig0;
  assign w_grant1 = resetn & w_elig1 & ~w_elig0;
`else
  logic r_prio;

  assign w_grant0 = resetn & w_elig0 & (~w_elig1 | ~r_prio);
  assign w_grant1 = resetn & w_elig1 & (~w_elig0 |  r_prio);

  // Priority always moves to the requester that was not served.
  always_ff @(posedge clk) begin
    if (!resetn)       r_prio <= 1'b0;
    else if (w_grant0) r_prio <= 1'b1;
    else if (w_grant1) r_prio <= 1'b0;
  end
`endif

  assign in0_ready = w_grant0;
  assign in1_ready = w_grant1;

  always_comb begin
    alu_scr0  = 32'd0;
    alu_scr1  = 32'd0;
    alu_aluop = 12'd0;
    if (w_grant0) begin
      alu_scr0  = in0_scr0;
      alu_scr1  = in0_scr1;
      alu_aluop = in0_aluop;
    end else if (w_grant1) begin
      alu_scr0  = in1_scr0;
      alu_scr1  = in1_scr1;
      alu_aluop = in1_aluop;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out0_valid    <= 1'b0;
      out0_result   <= 32'd0;
      out0_overflow <= 1'b0;
    end else if (w_grant0) begin
      out0_valid    <= 1'b1;
      out0_result   <= alu_aluso;
      out0_overflow <= alu_overflow;
    end else if (out0_ready) begin
      out0_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out1_valid    <= 1'b0;
      out1_result   <= 32'd0;
      out1_overflow <= 1'b0;
    end else if (w_grant1) begin
      out1_valid    <= 1'b1;
      out1_result   <= alu_aluso;
      out1_overflow <= alu_overflow;
    end else if (out1_ready) begin
      out1_valid    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_share_arb : directed + random checks of alu_share_arb against a
//                    transaction-level reference model. Revision 1.0
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid [2];
  logic [31:0] in_a     [2];
  logic [31:0] in_b     [2];
  logic [11:0] in_op    [2];
  logic        out_rdy  [2];

  logic        in0_ready, in1_ready, out0_valid, out1_valid;
  logic        out0_overflow, out1_overflow, alu_overflow;
  logic [31:0] out0_result, out1_result, alu_scr0, alu_scr1, alu_aluso;
  logic [11:0] alu_aluop;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .resetn(resetn),
    .in0_valid(in_valid[0]), .in0_ready(in0_ready),
    .in0_scr0(in_a[0]), .in0_scr1(in_b[0]), .in0_aluop(in_op[0]),
    .in1_valid(in_valid[1]), .in1_ready(in1_ready),
    .in1_scr0(in_a[1]), .in1_scr1(in_b[1]), .in1_aluop(in_op[1]),
    .out0_valid(out0_valid), .out0_ready(out_rdy[0]),
    .out0_result(out0_result), .out0_overflow(out0_overflow),
    .out1_valid(out1_valid), .out1_ready(out_rdy[1]),
    .out1_result(out1_result), .out1_overflow(out1_overflow),
    .alu_scr0(alu_scr0), .alu_scr1(alu_scr1), .alu_aluop(alu_aluop),
    .alu_aluso(alu_aluso), .alu_overflow(alu_overflow)
  );

  // Shared ALU: {overflow, result}; ops MSB first add..lui, scr0 = shift amount.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [11:0] op);
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    if (op[11]) begin
      r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op[10]) begin
      r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (op[9]) r = a & b;
    else if (op[8]) r = a | b;
    else if (op[7]) r = ~(a | b);
    else if (op[6]) r = a ^ b;
    else if (op[5]) r = {31'd0, $signed(a) < $signed(b)};
    else if (op[4]) r = {31'd0, a < b};
    else if (op[3]) r = b << a[4:0];
    else if (op[2]) r = b >> a[4:0];
    else if (op[1]) r = $unsigned($signed(b) >>> a[4:0]);
    else if (op[0]) r = {b[15:0], 16'd0};
    return {v, r};
  endfunction

  always_comb {alu_overflow, alu_aluso} = alu_f(alu_scr0, alu_scr1, alu_aluop);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-requester result slot plus whose turn it is.
  bit          m_v [2];
  logic [31:0] m_r [2];
  bit          m_o [2];
  int          m_prio;
  bit          obs_rdy0, obs_rdy1;
  logic [11:0] obs_op;

  // One clock: check all outputs mid-cycle, advance model at the edge.
  task automatic cycle();
    int          win;
    bit          e0, e1;
    logic [32:0] res;
    #4;
    e0  = in_valid[0] && (!m_v[0] || out_rdy[0]);
    e1  = in_valid[1] && (!m_v[1] || out_rdy[1]);
    win = -1;
    if (resetn) begin
      if (e0 && e1) win = FIXED ? 0 : m_prio;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
    end
    obs_rdy0 = in0_ready;
    obs_rdy1 = in1_ready;
    obs_op   = alu_aluop;
    chk("in0_ready", in0_ready, win == 0);
    chk("in1_ready", in1_ready, win == 1);
    chk("alu_aluop", alu_aluop, (win < 0) ? 12'd0 : in_op[win]);
    chk("alu_scr0",  alu_scr0,  (win < 0) ? 32'd0 : in_a[win]);
    chk("alu_scr1",  alu_scr1,  (win < 0) ? 32'd0 : in_b[win]);
    chk("out0_valid", out0_valid, m_v[0]);
    chk("out1_valid", out1_valid, m_v[1]);
    if (m_v[0]) begin
      chk("out0_result", out0_result, m_r[0]);
      chk("out0_overflow", out0_overflow, m_o[0]);
    end
    if (m_v[1]) begin
      chk("out1_result", out1_result, m_r[1]);
      chk("out1_overflow", out1_overflow, m_o[1]);
    end
    @(posedge clk);
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_r[i] = 0; m_o[i] = 0; end
      m_prio = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (win == i) begin
          res = alu_f(in_a[i], in_b[i], in_op[i]);
          m_v[i] = 1; m_r[i] = res[31:0]; m_o[i] = res[32];
        end else if (out_rdy[i]) begin
          m_v[i] = 0;
        end
      end
      if (win >= 0) m_prio = 1 - win;
    end
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; in_a[i] = 0; in_b[i] = 0; in_op[i] = 0; out_rdy[i] = 0;
    end
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    cycle();
    resetn = 1;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [31:0] b,
                     input logic [11:0] op);
    in_valid[i] = 1; in_a[i] = a; in_b[i] = b; in_op[i] = op;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_FFFF & 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  localparam logic [11:0] OP_ADD = 12'b1000_0000_0000;
  localparam logic [11:0] OP_SUB = 12'b0100_0000_0000;
  localparam logic [11:0] OP_SLL = 12'b0000_0000_1000;

  initial begin
    idle();
    resetn = 0;
    in_valid[0] = 1; in_valid[1] = 1; in_op[0] = OP_ADD; in_op[1] = OP_SUB;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_alu_aluop", alu_aluop, 0);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_result", out0_result, 0);
    chk("rst_out1_overflow", out1_overflow, 0);
    for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_r[i] = 0; m_o[i] = 0; end
    m_prio = 0;
    do_reset();

    // add 5+7 on requester 0 alone
    req(0, 32'd5, 32'd7, OP_ADD);
    cycle();
    chk("add_ready", obs_rdy0, 1);
    idle();
    chk("add_valid", out0_valid, 1);
    chk("add_result", out0_result, 32'd12);
    chk("add_ovf", out0_overflow, 0);
    out_rdy[0] = 1;
    cycle();

    // both requesters contend every cycle with results always consumed
    do_reset();
    req(0, 32'd1, 32'd2, OP_ADD);
    req(1, 32'd9, 32'd4, OP_SUB);
    out_rdy[0] = 1; out_rdy[1] = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_grant0", obs_rdy0, FIXED ? 1'b1 : (k % 2 == 0));
      chk("rr_grant1", obs_rdy1, FIXED ? 1'b0 : (k % 2 == 1));
    end

    // sub overflow held while requester 1 stalls its result
    do_reset();
    req(1, 32'h8000_0000, 32'd1, OP_SUB);
    cycle();
    chk("sub_ready", obs_rdy1, 1);
    req(1, 32'd1, 32'd1, OP_ADD);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_ready", obs_rdy1, 0);
      chk("stall_result", out1_result, 32'h7FFF_FFFF);
      chk("stall_ovf", out1_overflow, 1);
      chk("stall_valid", out1_valid, 1);
    end
    out_rdy[1] = 1;
    cycle();
    chk("refill_ready", obs_rdy1, 1);
    chk("refill_result", out1_result, 32'd2);
    idle();
    out_rdy[1] = 1;
    cycle();
    chk("drain_valid", out1_valid, 0);

    // back-to-back shifts at full throughput
    do_reset();
    req(0, 32'd4, 32'd1, OP_SLL);
    out_rdy[0] = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("sll_valid", out0_valid, 1);
      chk("sll_result", out0_result, 32'd16);
    end

    // reset while a result is pending and requester 1 waits
    do_reset();
    req(0, 32'd3, 32'd4, OP_ADD);
    cycle();
    idle();
    req(1, 32'd100, 32'd1, OP_SUB);
    resetn = 0;
    cycle();
    chk("mid_rst_ready1", obs_rdy1, 0);
    chk("mid_rst_op", obs_op, 0);
    chk("mid_rst_out0_valid", out0_valid, 0);
    chk("mid_rst_out1_valid", out1_valid, 0);
    resetn = 1;
    req(0, 32'd20, 32'd22, OP_ADD);
    cycle();
    chk("post_rst_grant0", obs_rdy0, 1);
    chk("post_rst_grant1", obs_rdy1, 0);
    chk("post_rst_out0", out0_result, 32'd42);
    chk("post_rst_out1_valid", out1_valid, 0);

    // random traffic, including non-one-hot ops and sporadic resets
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_a[i]     = rnd_operand();
        in_b[i]     = rnd_operand();
        in_op[i]    = ($urandom_range(0, 9) != 0) ? (12'd1 << $urandom_range(0, 11))
                                                   : 12'($urandom);
        out_rdy[i]  = ($urandom_range(0, 2) != 0);
      end
      resetn = ($urandom_range(0, 99) != 0);
      cycle();
    end
    resetn = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
